jtframe_pll_cen: RTL and testbench
==================================

Name: jtframe_pll_cen

Overview:
- Synthesizable, parametrised replacement for the fixed simulation-only PLL divider models.
- Derives CH independent fractional clock-enable channels (n/m of clk) from a single fast clock.
- Each channel provides a 0° enable (cen) and a 180° enable (cenb).
- Emulates PLL lock behaviour with a programmable lock delay, so downstream cores see a realistic `locked` rise.

Parameters:
- CH, 4, number of enable channels.
- W, 10, width of each channel's n and m ratio fields.
- LOCK_DLY, 16, clk edges after reset release before locked asserts (≥1).

Ports:
- clk  in  1  fast master clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  global run enable; 0 freezes all channels.
- n  in  CH*W  per-channel numerator; channel k in bits [k*W +: W].
- m  in  CH*W  per-channel denominator; same packing.
- cen  out  CH  one-cycle enable pulses at rate n/m of clk.
- cenb  out  CH  same rate as cen, offset by half a period.
- locked  out  1  high once the lock delay has elapsed.

Behaviour:
- Reset (rst_n=0, takes effect immediately):
  - cen=0, cenb=0, locked=0.
  - Lock counter=0.
  - Per-channel acc=0, accb=0, and registered copies of n and m = 0.
- Lock counter:
  - Increments each edge while locked=0.
  - At the edge where counter==LOCK_DLY-1, locked<=1, so locked is high after the LOCK_DLY-th edge following reset release.
  - locked then stays high until the next reset.
- While locked=0, every channel is held in preload: acc<=0, accb<=m>>1, cen=cenb=0.
- Accumulator width is W+1 bits, which prevents overflow of acc+n.
- Per channel, on each edge with locked=1 and en=1 (effective n' = min(n,m)):
  - If acc+n' >= m: acc<=acc+n'-m and cen<=1. Otherwise acc<=acc+n' and cen<=0.
  - accb and cenb follow the identical rule.
  - Outputs are registered: a pulse is visible for one cycle, starting after the edge that detected the crossing.
- Channel boundary conditions:
  - m=0: channel disabled; acc, accb, cen and cenb all held at 0.
  - n=0: no pulses.
  - n ≥ m: cen=cenb=1 every active cycle.
- Ratio change: a channel's n or m differing from its registered copy at an edge causes, on that edge:
  - Copies updated.
  - acc<=0, accb<=m>>1.
  - cen=cenb=0 for that cycle; normal accumulation resumes on the next edge.
  - Other channels are unaffected.
- en=0: accumulators hold and cen=cenb=0. On re-enable, counting continues from the held state with no reinit.
- If a ratio change and en=0 occur on the same edge, the reinit still applies.
- Simultaneous cen and cenb on a channel is legal (e.g. n ≥ m).

Optional Feature:
- Macro: JTFRAME_PLL_CEN_CNT_EN.
- When defined:
  - Adds output port cen_cnt (CH*16): a free-running per-channel count of cen pulses, wrapping at 16'hFFFF→0.
  - Counters reset to 0 on rst_n=0 and on a channel ratio reinit.
- When undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, LOCK_DLY=16 → locked=0 through edge 15, 1 after edge 16; cen/cenb stay 0 throughout; mid-run rst_n=0 clears locked, cen and cenb asynchronously without waiting for a clk edge.
- ch0 n=1, m=4, en=1 → cenb pulses after edges 2, 6, 10…, cen after edges 4, 8, 12… counted from lock; exactly one-cycle pulses.
- ch1 n=3, m=8 → cen interval pattern 3,3,2 repeating; 3 pulses per 8 cycles; measured over 800 cycles gives exactly 300.
- Boundaries: n=0,m=4 → no pulses; n=5,m=4 → cen=cenb=1 every cycle; m=0 → channel silent while other channels run normally.
- ch0 running 1/4, change to n=1, m=2 mid-period → zero pulses on the change edge; then cenb next edge, cen second edge, alternating each cycle; ch2 timing unaffected.
- en=0 for 5 cycles mid-period (n=1, m=4, acc=2) → no pulses while low; after en=1, cen arrives 2 edges later. With JTFRAME_PLL_CEN_CNT_EN, cen_cnt matches the bench's pulse count, including wrap after 65536 pulses.

Source files
------------

// File: rtl/jtframe_pll_cen.sv
// Fractional clock-enable generator: CH channels of n/m-rate cen/cenb pulses with emulated PLL lock.
// Optional macro JTFRAME_PLL_CEN_CNT_EN adds per-channel 16-bit cen pulse counters on cen_cnt.
module jtframe_pll_cen #(
    parameter int CH       = 4,
    parameter int W        = 10,
    parameter int LOCK_DLY = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [CH*W-1:0] n,
    input  logic [CH*W-1:0] m,
    output logic [CH-1:0]   cen,
    output logic [CH-1:0]   cenb,
`ifdef JTFRAME_PLL_CEN_CNT_EN
    output logic [CH*16-1:0] cen_cnt,
`endif
    output logic            locked
);

    localparam int CW = $clog2(LOCK_DLY + 1);
    localparam logic [CW-1:0] LAST = CW'(LOCK_DLY - 1);

    logic [CW-1:0] lock_cnt;

    // n is clamped to m so that n >= m simply yields a pulse every active cycle
    function automatic logic [W:0] eff_n(input logic [W-1:0] nv, input logic [W-1:0] mv);
        return (nv > mv) ? {1'b0, mv} : {1'b0, nv};
    endfunction

    // Returns {pulse, next accumulator}
    function automatic logic [W+1:0] acc_step(input logic [W:0] acc, input logic [W:0] inc,
                                              input logic [W-1:0] mv);
        logic [W:0] sum;
        sum = acc + inc;
        if (sum >= {1'b0, mv})
            return {1'b1, sum - {1'b0, mv}};
        else
            return {1'b0, sum};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else if (!locked) begin
            lock_cnt <= lock_cnt + CW'(1);
            if (lock_cnt == LAST) locked <= 1'b1;
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic [W-1:0] nk, mk, n_p0, m_p0;
        logic [W:0]   acc_p0, accb_p0;
        logic [W+1:0] stp, stpb;
        logic         cen_p0, cenb_p0;
        logic         reinit;

        assign nk     = n[k*W +: W];
        assign mk     = m[k*W +: W];
        assign stp    = acc_step(acc_p0,  eff_n(nk, mk), mk);
        assign stpb   = acc_step(accb_p0, eff_n(nk, mk), mk);
        assign reinit = (nk != n_p0) || (mk != m_p0);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                n_p0    <= '0;
                m_p0    <= '0;
                acc_p0  <= '0;
                accb_p0 <= '0;
                cen_p0  <= 1'b0;
                cenb_p0 <= 1'b0;
            end else if (!locked || reinit) begin
                // Preload and ratio reinit share the same start state: cenb leads cen by half a period
                n_p0    <= nk;
                m_p0    <= mk;
                acc_p0  <= '0;
                accb_p0 <= {1'b0, mk >> 1};
                cen_p0  <= 1'b0;
                cenb_p0 <= 1'b0;
            end else if (m_p0 == '0) begin
                acc_p0  <= '0;
                accb_p0 <= '0;
                cen_p0  <= 1'b0;
                cenb_p0 <= 1'b0;
            end else if (en) begin
                acc_p0  <= stp[W:0];
                accb_p0 <= stpb[W:0];
                cen_p0  <= stp[W+1];
                cenb_p0 <= stpb[W+1];
            end else begin
                cen_p0  <= 1'b0;
                cenb_p0 <= 1'b0;
            end
        end

        assign cen[k]  = cen_p0;
        assign cenb[k] = cenb_p0;

`ifdef JTFRAME_PLL_CEN_CNT_EN
        logic [15:0] cnt_p0;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_p0 <= '0;
            end else if (locked && reinit) begin
                cnt_p0 <= '0;
            end else if (locked && en && m_p0 != '0 && stp[W+1]) begin
                cnt_p0 <= cnt_p0 + 16'd1;
            end
        end

        assign cen_cnt[k*16 +: 16] = cnt_p0;
`endif
    end

endmodule

// File: tb/tb_jtframe_pll_cen.sv
// Directed bench for jtframe_pll_cen: lock timing, ratios, boundaries, ratio change, en gating, async reset.
// Counter checks are compiled in when JTFRAME_PLL_CEN_CNT_EN is defined.
module tb_jtframe_pll_cen;

    localparam int CH = 4, W = 10, LOCK_DLY = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic [W-1:0] nv [CH];
    logic [W-1:0] mv [CH];
    logic [CH*W-1:0] n, m;
    logic [CH-1:0] cen, cenb;
    logic locked;
`ifdef JTFRAME_PLL_CEN_CNT_EN
    logic [CH*16-1:0] cen_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int ec = 0;

    assign n = {nv[3], nv[2], nv[1], nv[0]};
    assign m = {mv[3], mv[2], mv[1], mv[0]};

    always #5 clk = ~clk;

    jtframe_pll_cen #(.CH(CH), .W(W), .LOCK_DLY(LOCK_DLY)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .n      (n),
        .m      (m),
        .cen    (cen),
        .cenb   (cenb),
`ifdef JTFRAME_PLL_CEN_CNT_EN
        .cen_cnt(cen_cnt),
`endif
        .locked (locked)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        ec++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [16:0] c1m, b1m;
        int p0, p1, p3, dbl;
        int r0, r2;
        logic prev0;

        nv[0] = 1; mv[0] = 4;
        nv[1] = 3; mv[1] = 8;
        nv[2] = 1; mv[2] = 4;
        nv[3] = 5; mv[3] = 4;
        en = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_locked", locked, 0);
        chk("rst_cen", cen, 0);
        chk("rst_cenb", cenb, 0);

        rst_n = 1'b1;
        for (int e = 1; e <= LOCK_DLY; e++) begin
            tick();
            chk("lock_locked", locked, (e == LOCK_DLY));
            chk("lock_quiet", cen | cenb, 0);
        end

        // ch1 3/8: cen after edges 3,6,8 and cenb after 2,4,7 in each 8-edge period
        ec = 0;
        c1m = (17'd1 << 3) | (17'd1 << 6) | (17'd1 << 8) | (17'd1 << 11) | (17'd1 << 14) | (17'd1 << 16);
        b1m = (17'd1 << 2) | (17'd1 << 4) | (17'd1 << 7) | (17'd1 << 10) | (17'd1 << 12) | (17'd1 << 15);
        for (int e = 1; e <= 16; e++) begin
            tick();
            chk("ratio_cen", cen, {1'b1, (ec % 4 == 0), c1m[ec], (ec % 4 == 0)});
            chk("ratio_cenb", cenb, {1'b1, (ec % 4 == 2), b1m[ec], (ec % 4 == 2)});
        end

        p0 = 0; p1 = 0; p3 = 0; dbl = 0;
        prev0 = cen[0];
        for (int i = 0; i < 800; i++) begin
            tick();
            p0 += int'(cen[0]);
            p1 += int'(cen[1]);
            p3 += int'(cen[3]);
            if (cen[0] && prev0) dbl++;
            prev0 = cen[0];
        end
        chk("count_ch1_3of8", p1, 300);
        chk("count_ch0_1of4", p0, 200);
        chk("count_ch3_full", p3, 800);
        chk("ch0_one_cycle", dbl, 0);

        // ch1 m=0 silent, ch2 n=0 silent, ch0 keeps its phase, ch3 n>m fires every cycle
        nv[2] = 0;
        mv[1] = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bnd_cen", cen, {1'b1, 1'b0, 1'b0, (ec % 4 == 0)});
            chk("bnd_cenb", cenb, {1'b1, 1'b0, 1'b0, (ec % 4 == 2)});
        end

        nv[2] = 1;
        r2 = ec + 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ch2_restart_cen", cen[2], ((ec - r2) > 0) && ((ec - r2) % 4 == 0));
            chk("ch2_restart_cenb", cenb[2], ((ec - r2) % 4 == 2));
        end

        // ch0 acc=3 here; switch to 1/2 so the change edge swallows a due pulse
        nv[0] = 1; mv[0] = 2;
        r0 = ec + 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ec == r0) begin
                chk("chg_edge_cen0", cen[0], 0);
                chk("chg_edge_cenb0", cenb[0], 0);
            end else begin
                chk("chg_cen0", cen[0], ((ec - r0) % 2 == 0));
                chk("chg_cenb0", cenb[0], ((ec - r0) % 2 == 1));
            end
            chk("chg_cen2", cen[2], ((ec - r2) % 4 == 0));
            chk("chg_cenb2", cenb[2], ((ec - r2) % 4 == 2));
            chk("chg_cen3", cen[3], 1);
        end

        mv[0] = 4;
        tick();
        chk("en_reinit", {cen[0], cenb[0]}, 2'b00);
        tick();
        chk("en_step1", {cen[0], cenb[0]}, 2'b00);
        tick();
        chk("en_step2", {cen[0], cenb[0]}, 2'b01);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("en_off_cen", cen, 0);
            chk("en_off_cenb", cenb, 0);
        end
        en = 1'b1;
        tick();
        chk("en_resume1", {cen[0], cenb[0]}, 2'b00);
        chk("en_resume1_ch3", cen[3], 1);
        tick();
        chk("en_resume2", {cen[0], cenb[0]}, 2'b10);

        chk("arst_pre", cen[3], 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_locked", locked, 0);
        chk("arst_cen", cen, 0);
        chk("arst_cenb", cenb, 0);

`ifdef JTFRAME_PLL_CEN_CNT_EN
        begin
            logic [15:0] pc [CH];
            tick();
            nv[0] = 1; mv[0] = 4;
            nv[1] = 3; mv[1] = 8;
            nv[2] = 0; mv[2] = 4;
            nv[3] = 5; mv[3] = 4;
            for (int k = 0; k < CH; k++) pc[k] = '0;
            rst_n = 1'b1;
            for (int i = 0; i < LOCK_DLY; i++) tick();
            for (int i = 0; i < 65541; i++) begin
                tick();
                for (int k = 0; k < CH; k++) pc[k] = pc[k] + {15'd0, cen[k]};
            end
            for (int k = 0; k < CH; k++) chk("cnt_match", cen_cnt[k*16 +: 16], pc[k]);
            chk("cnt_wrap_ch3", cen_cnt[63:48], 16'd5);
            chk("cnt_ch0", cen_cnt[15:0], 16'd16385);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
